alu_issue_ctrl: RTL and testbench

Sequencing front end that drives the combinational ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8x16 register file. It presents op/op1/op2/en to the ALU, captures result and flags, writes the result back, and returns a response beat. This block is the ALU's upstream owner; it sits between the instruction source and the ALU instance.

---
 rtl/alu_issue_ctrl_pkg.sv | 49 ++++
 rtl/alu_issue_ctrl_regfile.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and encoding constants for the ALU issue controller and its register file.
package alu_issue_ctrl_pkg;

  localparam int NREGS_DEF = 8;
  localparam int DW_DEF    = 16;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    GTE  = 3'd2,
    LT   = 3'd3,
    NOT1 = 3'd4,
    LDI  = 3'd5
  } operation_t;

  typedef struct packed {
    logic carry;
  } flags_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  localparam logic [2:0] OPC_ADD  = 3'd0;
  localparam logic [2:0] OPC_SUB  = 3'd1;
  localparam logic [2:0] OPC_GTE  = 3'd2;
  localparam logic [2:0] OPC_LT   = 3'd3;
  localparam logic [2:0] OPC_NOT1 = 3'd4;
  localparam logic [2:0] OPC_LDI  = 3'd5;

  localparam int OPC_LSB = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  localparam int IMM_W   = 10;

  function automatic logic isLegal(input logic [2:0] opc);
    return (opc <= OPC_LDI);
  endfunction

  function automatic logic usesAlu(input logic [2:0] opc);
    return (opc <= OPC_NOT1);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port, async clear.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr1,
  input  logic [$clog2(NREGS)-1:0] i_raddr2,
  output logic [DW-1:0]            o_rdata1,
  output logic [DW-1:0]            o_rdata2
);

  logic [DW-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction at a time, reads operands, drives the external
// ALU for a single cycle, writes the result back and returns a response beat.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ins_valid,
  output logic          ins_ready,
  input  logic [15:0]   ins_data,
  output logic          alu_en,
  output operation_t    alu_op,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  input  logic [DW-1:0] alu_result,
  input  flags_t        alu_fls,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    rsp_rd,
  output logic          rsp_err,
  output logic          carry_q
);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_ins;
  operation_t    r_alu_op;
  logic [DW-1:0] r_op1;
  logic [DW-1:0] r_op2;
  logic [DW-1:0] r_res;
  logic          r_fls_carry;
  logic [DW-1:0] r_rsp_data;
  logic [2:0]    r_rsp_rd;
  logic          r_rsp_err;
  logic          r_carry_q;

  logic [2:0]    w_opc;
  logic [2:0]    w_rd;
  logic [2:0]    w_rs1;
  logic [2:0]    w_rs2;
  logic [DW-1:0] w_rdata1;
  logic [DW-1:0] w_rdata2;
  logic [DW-1:0] w_wdata;
  logic          w_we;
  logic          w_legal;

  assign w_opc   = r_ins[OPC_LSB +: 3];
  assign w_rd    = r_ins[RD_LSB  +: 3];
  assign w_rs1   = r_ins[RS1_LSB +: 3];
  assign w_rs2   = r_ins[RS2_LSB +: 3];
  assign w_legal = isLegal(w_opc);
  assign w_we    = (r_state == S_WB) && w_legal;

  alu_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_wdata),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // LDI and illegal opcodes never touch the ALU, so they bypass EXEC.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ins_valid) w_next = S_READ;
      S_READ: w_next = usesAlu(w_opc) ? S_EXEC : S_WB;
      S_EXEC: w_next = S_WB;
      S_WB:   w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // GTE/LT results come from the borrow flag rather than the ALU result word.
  always_comb begin
    w_wdata = '0;
    case (w_opc)
      OPC_ADD, OPC_SUB, OPC_NOT1: w_wdata = r_res;
      OPC_GTE: w_wdata = {{(DW-1){1'b0}}, ~r_fls_carry};
      OPC_LT:  w_wdata = {{(DW-1){1'b0}}, r_fls_carry};
      OPC_LDI: w_wdata = {{(DW-IMM_W){1'b0}}, r_ins[IMM_W-1:0]};
      default: w_wdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ins       <= '0;
      r_alu_op    <= ADD;
      r_op1       <= '0;
      r_op2       <= '0;
      r_res       <= '0;
      r_fls_carry <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_rd    <= '0;
      r_rsp_err   <= 1'b0;
      r_carry_q   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (ins_valid) r_ins <= ins_data;
        S_READ: begin
          if (usesAlu(w_opc)) begin
            r_alu_op <= operation_t'(w_opc);
            r_op1    <= w_rdata1;
            r_op2    <= w_rdata2;
          end
        end
        S_EXEC: begin
          r_res       <= alu_result;
          r_fls_carry <= alu_fls.carry;
        end
        S_WB: begin
          r_rsp_data <= w_wdata;
          r_rsp_rd   <= w_rd;
          r_rsp_err  <= ~w_legal;
          if (w_opc <= OPC_LT) r_carry_q <= r_fls_carry;
        end
        default: ;
      endcase
    end
  end

  assign ins_ready = (r_state == S_IDLE);
  assign alu_en    = (r_state == S_EXEC);
  assign alu_op    = r_alu_op;
  assign alu_op1   = r_op1;
  assign alu_op2   = r_op2;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_err   = r_rsp_err;
  assign carry_q   = r_carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and an architectural
// reference model of the register file and sticky carry.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_valid;
  logic        ins_ready;
  logic [15:0] ins_data;
  logic        alu_en;
  operation_t  alu_op;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [15:0] alu_result;
  flags_t      alu_fls;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_err;
  logic        carry_q;

  int          checks = 0;
  int          errors = 0;
  int          enCount = 0;
  logic        junkCarry = 1'b0;
  logic [15:0] lastData;
  int          lastLat;
  logic [15:0] model [8];
  logic        modelCarry;

  alu_issue_ctrl #(.NREGS(8), .DW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_data   (ins_data),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .alu_fls    (alu_fls),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .rsp_err    (rsp_err),
    .carry_q    (carry_q)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: carry is carry-out for ADD and borrow for SUB/GTE/LT; NOT1 carry is junk.
  always_comb begin
    alu_result = 16'hDEAD;
    alu_fls    = '0;
    case (alu_op)
      ADD: {alu_fls.carry, alu_result} = {1'b0, alu_op1} + {1'b0, alu_op2};
      SUB, GTE, LT: begin
        alu_result    = alu_op1 - alu_op2;
        alu_fls.carry = (alu_op1 < alu_op2);
      end
      NOT1: begin
        alu_result    = ~alu_op1;
        alu_fls.carry = junkCarry;
      end
      default: ;
    endcase
  end

  always @(negedge clk) if (alu_en) enCount++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [2:0] opc, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {opc, rd, rs1, rs2, 4'h0};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'd5, rd, imm};
  endfunction

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_ins_ready"}, ins_ready, 1);
    checkOutput({pfx, "_alu_en"}, alu_en, 0);
    checkOutput({pfx, "_alu_op"}, alu_op, ADD);
    checkOutput({pfx, "_alu_op1"}, alu_op1, 0);
    checkOutput({pfx, "_alu_op2"}, alu_op2, 0);
    checkOutput({pfx, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({pfx, "_rsp_data"}, rsp_data, 0);
    checkOutput({pfx, "_rsp_rd"}, rsp_rd, 0);
    checkOutput({pfx, "_rsp_err"}, rsp_err, 0);
    checkOutput({pfx, "_carry_q"}, carry_q, 0);
  endtask

  // Issues one instruction, checks the response against the model, then retires it.
  task automatic applyStimulus(input logic [15:0] ins, input int hold, input logic early);
    logic [2:0]  opc, rd;
    logic [15:0] a, b, expData;
    logic        expCarry, expErr;
    int          s, lat, guard, expLat, expEn;
    opc = ins[15:13];
    rd  = ins[12:10];
    a   = model[ins[9:7]];
    b   = model[ins[6:4]];
    expCarry = modelCarry;
    expErr   = 1'b0;
    expData  = 16'h0;
    case (opc)
      3'd0: begin s = int'(a) + int'(b); expData = 16'(s % 65536); expCarry = (s > 65535); end
      3'd1: begin s = int'(a) - int'(b); expData = 16'((s + 65536) % 65536); expCarry = (a < b); end
      3'd2: begin expData = (a >= b) ? 16'd1 : 16'd0; expCarry = (a < b); end
      3'd3: begin expData = (a < b) ? 16'd1 : 16'd0; expCarry = (a < b); end
      3'd4: expData = ~a;
      3'd5: expData = {6'd0, ins[9:0]};
      default: expErr = 1'b1;
    endcase
    expLat = (opc <= 3'd4) ? 4 : 3;
    expEn  = (opc <= 3'd4) ? 1 : 0;

    junkCarry = 1'($urandom);
    rsp_ready = early;
    ins_data  = ins;
    ins_valid = 1'b1;
    guard = 0;
    while (!ins_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput("ins_ready_wait", ins_ready, 1);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    ins_data  = 16'($urandom);
    enCount   = 0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    lastLat  = lat;
    lastData = rsp_data;
    checkOutput("rsp_valid_seen", rsp_valid, 1);
    checkOutput("latency", lat, expLat);
    checkOutput("rsp_data", rsp_data, expData);
    checkOutput("rsp_rd", rsp_rd, rd);
    checkOutput("rsp_err", rsp_err, expErr);
    checkOutput("carry_q", carry_q, expCarry);
    checkOutput("alu_en_cycles", enCount, expEn);
    checkOutput("busy_ins_ready", ins_ready, 0);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        checkOutput("hold_rsp_valid", rsp_valid, 1);
        checkOutput("hold_rsp_data", rsp_data, expData);
        checkOutput("hold_rsp_rd", rsp_rd, rd);
        checkOutput("hold_rsp_err", rsp_err, expErr);
        checkOutput("hold_ins_ready", ins_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_drop", rsp_valid, 0);
    checkOutput("idle_ins_ready", ins_ready, 1);

    if (!expErr) model[rd] = expData;
    if (opc <= 3'd3) modelCarry = expCarry;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    modelCarry = 1'b0;
    rst_n     = 1'b0;
    ins_valid = 1'b0;
    ins_data  = 16'h0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(ldi(3'd1, 10'h3FF), 0, 1'b0);
    applyStimulus(enc(3'd0, 3'd2, 3'd1, 3'd1), 1, 1'b0);
    checkOutput("add_7fe", lastData, 16'h07FE);
    checkOutput("add_7fe_carry", carry_q, 0);
    applyStimulus(enc(3'd4, 3'd3, 3'd0, 3'd0), 0, 1'b1);
    checkOutput("not1_ffff", lastData, 16'hFFFF);
    applyStimulus(enc(3'd0, 3'd4, 3'd3, 3'd3), 2, 1'b0);
    checkOutput("add_fffe", lastData, 16'hFFFE);
    checkOutput("add_fffe_carry", carry_q, 1);

    applyStimulus(ldi(3'd1, 10'd5), 0, 1'b0);
    applyStimulus(ldi(3'd2, 10'd7), 0, 1'b1);
    applyStimulus(enc(3'd1, 3'd3, 3'd1, 3'd2), 0, 1'b0);
    checkOutput("sub_borrow", lastData, 16'hFFFE);
    checkOutput("sub_carry", carry_q, 1);
    applyStimulus(enc(3'd3, 3'd4, 3'd1, 3'd2), 0, 1'b0);
    checkOutput("lt_5_7", lastData, 16'h0001);
    applyStimulus(enc(3'd2, 3'd5, 3'd1, 3'd2), 0, 1'b0);
    checkOutput("gte_5_7", lastData, 16'h0000);
    applyStimulus(enc(3'd2, 3'd6, 3'd2, 3'd2), 0, 1'b0);
    checkOutput("gte_7_7", lastData, 16'h0001);

    applyStimulus(enc(3'd1, 3'd3, 3'd1, 3'd2), 0, 1'b0);
    applyStimulus(enc(3'd4, 3'd7, 3'd0, 3'd0), 6, 1'b0);
    checkOutput("not1_iso_data", lastData, 16'hFFFF);
    checkOutput("not1_iso_carry", carry_q, 1);

    applyStimulus({3'b110, 3'd2, 10'h3A5}, 0, 1'b0);
    checkOutput("illegal_data", lastData, 16'h0000);
    checkOutput("illegal_lat", lastLat, 3);
    applyStimulus(enc(3'd0, 3'd2, 3'd2, 3'd0), 0, 1'b0);
    checkOutput("illegal_reread", lastData, 16'h0007);
    applyStimulus({3'b111, 3'd1, 10'h155}, 1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    applyStimulus(ldi(3'd2, 10'h123), 0, 1'b0);
    applyStimulus(ldi(3'd3, 10'h045), 0, 1'b0);
    ins_data  = enc(3'd0, 3'd1, 3'd2, 3'd3);
    ins_valid = 1'b1;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("exec_before_reset", alu_en, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    modelCarry = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(enc(3'd0, 3'd1, 3'd2, 3'd3), 0, 1'b0);
    checkOutput("post_reset_add", lastData, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
